// File: rtl/pattern_scan_ctrl.sv
// Serial pattern detector: configurable pattern/length/overlap, start/stop scan control.
// Define PATTERN_SCAN_COUNT_EN to build the saturating detection counter.
module pattern_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         in_valid,
    input  logic                         inbit,
    output logic                         busy,
    output logic                         detect,
    output logic [CNT_W-1:0]             det_count,
    output logic                         count_sat,
    output logic                         cfg_err
);
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
    localparam logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1001);
    localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'(4);

    typedef enum logic {IDLE, SCAN} state_t;
    state_t state, state_nxt;

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic [PAT_W-1:0] pat_p1, hist_p1, hist_shift, len_mask;
    logic [LEN_W-1:0] len_p1, fill_p1, fill_inc;
    logic             ovl_p1, detect_p1, cfg_err_p1;
    logic             cfg_take, cfg_legal, scan_start, scan_stop, sample, match;

    // Assert asynchronously, release two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (start && !stop) state_nxt = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cfg_take   = (state == IDLE) && cfg_valid;
    assign cfg_legal  = (cfg_len != '0) && (cfg_len <= MAX_LEN);
    assign scan_start = (state == IDLE) && start && !stop;
    assign scan_stop  = (state == SCAN) && stop;
    assign sample     = (state == SCAN) && !stop && in_valid;
    assign hist_shift = {hist_p1[PAT_W-2:0], inbit};
    assign fill_inc   = (fill_p1 >= MAX_LEN) ? MAX_LEN : fill_p1 + 1'b1;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) len_mask[i] = (LEN_W'(i) < len_p1);
    end

    assign match = (((hist_shift ^ pat_p1) & len_mask) == '0) && (fill_inc >= len_p1);

    // Shadow configuration; illegal offers only raise the sticky error.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pat_p1     <= DEF_PAT;
            len_p1     <= DEF_LEN;
            ovl_p1     <= 1'b0;
            cfg_err_p1 <= 1'b0;
        end else if (cfg_take) begin
            if (cfg_legal) begin
                pat_p1     <= cfg_pattern;
                len_p1     <= cfg_len;
                ovl_p1     <= cfg_overlap;
                cfg_err_p1 <= 1'b0;
            end else begin
                cfg_err_p1 <= 1'b1;
            end
        end
    end

    // Non-overlap mode restarts the fill so matched bits cannot be reused.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            hist_p1   <= '0;
            fill_p1   <= '0;
            detect_p1 <= 1'b0;
        end else begin
            detect_p1 <= sample && match;
            if (scan_start) begin
                fill_p1 <= '0;
            end else if (scan_stop) begin
                hist_p1 <= '0;
                fill_p1 <= '0;
            end else if (sample) begin
                hist_p1 <= hist_shift;
                fill_p1 <= (match && !ovl_p1) ? '0 : fill_inc;
            end
        end
    end

    assign detect  = detect_p1;
    assign cfg_err = cfg_err_p1;

`ifdef PATTERN_SCAN_COUNT_EN
    logic [CNT_W-1:0] cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)           cnt_p1 <= '0;
        else if (scan_start)      cnt_p1 <= '0;
        else if (sample && match) cnt_p1 <= sat_inc(cnt_p1);
    end

    assign det_count = cnt_p1;
    assign count_sat = &cnt_p1;
`else
    assign det_count = '0;
    assign count_sat = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: per-cycle comparison against a queue-based
// reference plus literal expectations for the documented scenarios.
module tb_pattern_scan_ctrl;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
`ifdef PATTERN_SCAN_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n, cfg_valid, cfg_ready, cfg_overlap;
    logic [PAT_W-1:0] cfg_pattern;
    logic [2:0]       cfg_len;
    logic             start, stop, in_valid, inbit;
    logic             busy, detect, count_sat, cfg_err;
    logic [CNT_W-1:0] det_count;

    int checks = 0;
    int errors = 0;

    pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .start(start), .stop(stop), .in_valid(in_valid), .inbit(inbit),
        .busy(busy), .detect(detect), .det_count(det_count),
        .count_sat(count_sat), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bits received since scan start (or last non-overlap match).
    logic [PAT_W-1:0] m_pat;
    int               m_len, m_cnt, rst_edges;
    bit               m_ovl, m_err, m_scan, m_det, hit;
    bit               m_bits[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pat = 4'b1001; m_len = 4; m_ovl = 0; m_err = 0;
            m_scan = 0; m_det = 0; m_cnt = 0; rst_edges = 0;
            m_bits.delete();
        end else if (rst_edges < 2) begin
            rst_edges++;
        end else begin
            m_det = 0;
            if (!m_scan) begin
                if (cfg_valid) begin
                    if (cfg_len >= 1 && cfg_len <= PAT_W) begin
                        m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap; m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                if (start && !stop) begin
                    m_scan = 1; m_cnt = 0; m_bits.delete();
                end
            end else if (stop) begin
                m_scan = 0; m_bits.delete();
            end else if (in_valid) begin
                m_bits.push_back(inbit);
                if (m_bits.size() > 16) void'(m_bits.pop_front());
                hit = (m_bits.size() >= m_len);
                for (int i = 0; i < m_len && hit; i++)
                    if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
                if (hit) begin
                    m_det = 1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    if (!m_ovl) m_bits.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_scan);
        chk("cfg_ready", cfg_ready, !m_scan);
        chk("detect", detect, m_det);
        chk("cfg_err", cfg_err, m_err);
        chk("det_count", det_count, CNT_EN ? m_cnt : 0);
        chk("count_sat", count_sat, (CNT_EN && m_cnt == (1 << CNT_W) - 1) ? 1 : 0);
    end

    function automatic int ec(input int n);
        return CNT_EN ? n : 0;
    endfunction

    task automatic drive(input bit cv, input bit st, input bit sp, input bit iv, input bit ib);
        cfg_valid = cv; start = st; stop = sp; in_valid = iv; inbit = ib;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 0; start = 0; stop = 0; in_valid = 0; inbit = 0;
    endtask

    // seq bit n-1 is sent first; det_mask bit i = detect expected after bit i+1
    task automatic send_seq(input logic [15:0] seq, input int n, input int det_mask);
        logic [15:0] s;
        s = seq;
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 1, s[n-1-i]);
            chk("seq_detect", detect, (det_mask >> i) & 1);
        end
    endtask

    task automatic configure(input logic [3:0] p, input logic [2:0] l, input bit o);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (3) drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 0; cfg_valid = 0; start = 0; stop = 0; in_valid = 0; inbit = 0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_detect", detect, 0);
        chk("rst_count", det_count, 0);
        chk("rst_sat", count_sat, 0);
        chk("rst_err", cfg_err, 0);
        reset_n = 1;
        repeat (3) drive(0, 0, 0, 0, 0);

        // Reset default pattern 1001, non-overlap
        drive(0, 1, 0, 0, 0);
        chk("t1_busy", busy, 1);
        send_seq(16'b0101001, 7, 1 << 6);
        chk("t1_count", det_count, ec(1));
        drive(0, 0, 1, 0, 0);
        chk("t1_idle", busy, 0);
        chk("t1_retain", det_count, ec(1));

        // Overlap mode
        configure(4'b1001, 3'd4, 1);
        drive(0, 1, 0, 0, 0);
        send_seq(16'b1001001, 7, (1 << 3) | (1 << 6));
        chk("t2_count", det_count, ec(2));
        drive(0, 0, 1, 0, 0);

        // Non-overlap mode
        configure(4'b1001, 3'd4, 0);
        drive(0, 1, 0, 0, 0);
        chk("t3_cleared", det_count, 0);
        send_seq(16'b1001001, 7, 1 << 3);
        chk("t3_count", det_count, ec(1));
        drive(0, 0, 1, 0, 0);

        // Illegal configuration keeps defaults
        do_reset();
        configure(4'b0110, 3'd0, 1);
        chk("t4_err_len0", cfg_err, 1);
        configure(4'b0110, 3'd5, 1);
        chk("t4_err_len5", cfg_err, 1);
        drive(0, 1, 0, 0, 0);
        send_seq(16'b1001, 4, 1 << 3);
        drive(0, 0, 1, 0, 0);
        chk("t4_err_hold", cfg_err, 1);
        configure(4'b0110, 3'd3, 0);
        chk("t4_err_clr", cfg_err, 0);

        // Pattern 110 with in_valid gaps, then stop on the final bit
        drive(0, 1, 0, 0, 0);
        send_seq(16'b0110, 4, 1 << 3);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0);
        chk("t5_gap", detect, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0);
        chk("t5_gap2", detect, 0);
        drive(0, 0, 0, 1, 0);
        chk("t5_gap_det", detect, 1);
        chk("t5_count", det_count, ec(2));
        send_seq(16'b11, 2, 0);
        drive(0, 0, 1, 1, 0);
        chk("t5_stop_det", detect, 0);
        chk("t5_stop_idle", busy, 0);
        chk("t5_stop_cnt", det_count, ec(2));
        drive(0, 1, 1, 0, 0);
        chk("t5_startstop", busy, 0);

        // Saturation, then asynchronous reset mid-scan
        drive(0, 1, 0, 0, 0);
        send_seq(16'b110110110110110, 15, (1 << 2) | (1 << 5) | (1 << 8) | (1 << 11) | (1 << 14));
        chk("t6_count", det_count, ec(3));
        chk("t6_sat", count_sat, CNT_EN ? 1 : 0);
        chk("t6_pre_busy", busy, 1);
        #1 reset_n = 0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_detect", detect, 0);
        chk("t6_rst_count", det_count, 0);
        chk("t6_rst_sat", count_sat, 0);
        chk("t6_rst_ready", cfg_ready, 1);
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (4) drive(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter PAT_W, default 4, maximum pattern length in bits; legal range 4..16.
REQ-002 Parameter CNT_W, default 8, width of the detection counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_valid  input  1  configuration request.
REQ-006 cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-007 cfg_pattern  input  PAT_W  pattern bits; bit cfg_len-1 is the first bit expected.
REQ-008 cfg_len  input  $clog2(PAT_W+1)  pattern length in bits.
REQ-009 cfg_overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
REQ-010 start  input  1  begin scanning.
REQ-011 stop  input  1  end scanning.
REQ-012 in_valid  input  1  inbit qualifier.
REQ-013 inbit  input  1  serial data bit.
REQ-014 busy  output  1  high while in SCAN.
REQ-015 detect  output  1  registered one-cycle match pulse.
REQ-016 det_count  output  CNT_W  saturating count of detections since the last start.
REQ-017 count_sat  output  1  high while det_count equals all-ones.
REQ-018 cfg_err  output  1  sticky flag: an illegal configuration was offered.

Function
REQ-019 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-020 In IDLE, cfg_ready SHALL be 1; in SCAN, cfg_ready SHALL be 0 and cfg_valid SHALL be ignored.
REQ-021 A handshake with 1 <= cfg_len <= PAT_W SHALL load pattern, length and overlap mode into shadow registers on that edge.
REQ-022 A handshake with cfg_len = 0 or cfg_len > PAT_W SHALL leave the shadow registers unchanged and set cfg_err.
REQ-023 cfg_err SHALL be cleared only by a legal handshake or by reset.
REQ-024 IDLE->SCAN SHALL occur on an edge with start=1 and stop=0; that edge SHALL clear the history fill count, det_count and count_sat.
REQ-025 When start=1 and stop=1 together in IDLE, stop SHALL win and the FSM SHALL stay in IDLE.
REQ-026 SCAN->IDLE SHALL occur on any edge with stop=1; inbit on that edge SHALL NOT be sampled.
REQ-027 On SCAN->IDLE, history SHALL be cleared and det_count SHALL be retained.
REQ-028 start in SCAN SHALL be ignored.
REQ-029 In SCAN with in_valid=1, inbit SHALL shift into the LSB of a PAT_W-bit history; the fill count SHALL increment and saturate at PAT_W.
REQ-030 In SCAN with in_valid=0, history, fill and outputs SHALL hold, and detect SHALL be 0.
REQ-031 A match SHALL be flagged when the shifted history and pattern agree in their low cfg_len bits and fill (after increment) >= cfg_len.
REQ-032 detect SHALL be 1 for exactly the cycle following the edge that sampled the final pattern bit (latency 1 edge); otherwise detect SHALL be 0.
REQ-033 In overlap mode, history SHALL be kept after a match, so 1001001 yields two detects for pattern 1001.
REQ-034 In non-overlap mode, fill SHALL be reset to 0 on a match, so 1001001 yields one detect.
REQ-035 Each match SHALL increment det_count by 1, saturating at 2^CNT_W-1, with no wrap.
REQ-036 busy SHALL equal (state == SCAN).

Reset
REQ-037 While reset_n=0: state=IDLE, history=0, fill=0, detect=0, det_count=0, count_sat=0, cfg_err=0, busy=0.
REQ-038 Shadow configuration SHALL reset to pattern 1001 (zero-extended), length 4, overlap 0.
REQ-039 Reset asserted mid-scan SHALL take effect immediately, without waiting for a clock edge.
REQ-040 Deassertion SHALL be synchronised to clk, so that the first active edge is clean.

Configuration
REQ-041 Macro PATTERN_SCAN_COUNT_EN defined: det_count and count_sat SHALL behave per REQ-016, REQ-017, REQ-024 and REQ-035.
REQ-042 Macro PATTERN_SCAN_COUNT_EN undefined: no counter logic SHALL be built, and det_count and count_sat SHALL be constant 0.
REQ-043 All other behaviour SHALL be identical with and without PATTERN_SCAN_COUNT_EN.

Verification
REQ-044 Reset defaults: start, then bits 0,1,0,1,0,0,1 -> one detect, after the last bit; det_count=1.
REQ-045 Overlap: configure 1001, len 4, overlap 1; bits 1,0,0,1,0,0,1 -> detects after bits 4 and 7; det_count=2.
REQ-046 Same stream with overlap 0 -> one detect, after bit 4; det_count=1.
REQ-047 Illegal config: cfg_len=0, then cfg_len=PAT_W+1 -> cfg_err=1 and defaults still active; then a legal len-3 pattern 110 -> cfg_err=0.
REQ-048 Control and gaps: in_valid gaps inside a pattern -> match unaffected; stop asserted on the final bit -> no detect, IDLE, count retained; start=stop=1 in IDLE -> stays IDLE.
REQ-049 Saturation: CNT_W=2 with 5 matches -> det_count=3 and count_sat=1; macro undefined -> det_count=0 throughout; reset_n pulsed mid-scan -> all outputs 0 immediately.
